// File: rtl/wb_intercon_pkg.sv
// Shared definitions for the Wishbone interconnect: arbiter FSM states,
// arbitration mode constants and index-width helper.
package wb_intercon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_ABORT = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_t;

  localparam int unsigned MODE_RR    = 0;
  localparam int unsigned MODE_FIXED = 1;

  // Width of a master index; a single master still gets a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_arb_pick.sv
// Combinational winner selection: round-robin after the last owner, or
// fixed priority with the lowest index winning.
module wb_arb_pick #(
  parameter int unsigned num_masters = 2,
  parameter int unsigned msb         = 1
) (
  input  logic [num_masters-1:0] req,
  input  logic [msb-1:0]         last,
  input  logic                   mode,
  output logic [msb-1:0]         winner,
  output logic                   valid
);

  logic [2*num_masters-1:0] dbl;
  logic [num_masters-1:0]   rot;

  // Rotate so bit 0 is the index just after the last owner.
  assign dbl   = {req, req};
  assign rot   = num_masters'(dbl >> (32'(last) + 32'd1));
  assign valid = |req;

  always_comb begin
    winner = '0;
    if (mode) begin
      for (int i = num_masters - 1; i >= 0; i--) begin
        if (req[i]) winner = msb'(i);
      end
    end else begin
      for (int j = num_masters - 1; j >= 0; j--) begin
        if (rot[j]) winner = msb'((32'(last) + 32'd1 + 32'(j)) % num_masters);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_qos.sv
// Multi-master Wishbone arbiter with round-robin or fixed-priority grant,
// owner hold across bursts and an optional stall watchdog that aborts the owner.
module wb_arbiter_qos
  import wb_intercon_pkg::*;
#(
  parameter int unsigned dw          = 32,
  parameter int unsigned aw          = 32,
  parameter int unsigned num_masters = 2,
  parameter int unsigned mode        = 0,
  parameter int unsigned timeout     = 0
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [num_masters*aw-1:0]     wbm_adr_i,
  input  logic [num_masters*dw-1:0]     wbm_dat_i,
  input  logic [num_masters*(dw/8)-1:0] wbm_sel_i,
  input  logic [num_masters-1:0]        wbm_we_i,
  input  logic [num_masters-1:0]        wbm_cyc_i,
  input  logic [num_masters-1:0]        wbm_stb_i,
  input  logic [num_masters*3-1:0]      wbm_cti_i,
  input  logic [num_masters*2-1:0]      wbm_bte_i,
  output logic [num_masters*dw-1:0]     wbm_dat_o,
  output logic [num_masters-1:0]        wbm_ack_o,
  output logic [num_masters-1:0]        wbm_err_o,
  output logic [num_masters-1:0]        wbm_rty_o,
  output logic [aw-1:0]                 wbs_adr_o,
  output logic [dw-1:0]                 wbs_dat_o,
  output logic [dw/8-1:0]               wbs_sel_o,
  output logic                          wbs_we_o,
  output logic                          wbs_cyc_o,
  output logic                          wbs_stb_o,
  output logic [2:0]                    wbs_cti_o,
  output logic [1:0]                    wbs_bte_o,
  input  logic [dw-1:0]                 wbs_dat_i,
  input  logic                          wbs_ack_i,
  input  logic                          wbs_err_i,
  input  logic                          wbs_rty_i,
  output logic [num_masters-1:0]        grant_o,
  output logic                          timeout_o
);

  localparam int unsigned sw  = dw / 8;
  localparam int unsigned msb = idx_width(num_masters);
  localparam int unsigned cw  = (timeout == 0) ? 1 : $clog2(timeout + 1);
  localparam logic [cw-1:0] wd_last = cw'((timeout == 0) ? 0 : timeout - 1);

  arb_state_t     state;
  logic [msb-1:0] owner;
  logic [msb-1:0] last_owner;
  logic [cw-1:0]  wd_cnt;

  logic [msb-1:0] pick_winner;
  logic           pick_valid;
  logic           in_own;
  logic           own_cyc;
  logic           slv_resp;
  logic           wd_count;
  logic           wd_fire;

  logic [aw-1:0] m_adr [num_masters];
  logic [dw-1:0] m_dat [num_masters];
  logic [sw-1:0] m_sel [num_masters];
  logic [2:0]    m_cti [num_masters];
  logic [1:0]    m_bte [num_masters];

  for (genvar g = 0; g < num_masters; g++) begin : g_unpack
    assign m_adr[g] = wbm_adr_i[g*aw +: aw];
    assign m_dat[g] = wbm_dat_i[g*dw +: dw];
    assign m_sel[g] = wbm_sel_i[g*sw +: sw];
    assign m_cti[g] = wbm_cti_i[g*3 +: 3];
    assign m_bte[g] = wbm_bte_i[g*2 +: 2];
  end

  wb_arb_pick #(
    .num_masters(num_masters),
    .msb        (msb)
  ) u_pick (
    .req   (wbm_cyc_i),
    .last  (last_owner),
    .mode  (mode == MODE_FIXED),
    .winner(pick_winner),
    .valid (pick_valid)
  );

  assign in_own   = (state == ST_OWN);
  assign own_cyc  = wbm_cyc_i[owner];
  assign slv_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign wd_count = in_own && wbm_stb_i[owner] && !slv_resp;
  assign wd_fire  = (timeout != 0) && wd_count && (wd_cnt == wd_last);

  // Arbitration FSM, owner tracking and stall watchdog.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= ST_IDLE;
      owner      <= '0;
      last_owner <= msb'(num_masters - 1);
      wd_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          wd_cnt <= '0;
          if (pick_valid) begin
            owner      <= pick_winner;
            last_owner <= pick_winner;
            state      <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (!own_cyc) begin
            state  <= ST_IDLE;
            wd_cnt <= '0;
          end else if (wd_fire) begin
            state  <= ST_ABORT;
            wd_cnt <= '0;
          end else if (wd_count) begin
            if (wd_cnt != '1) wd_cnt <= wd_cnt + 1'b1;
          end else begin
            wd_cnt <= '0;
          end
        end
        ST_ABORT: state <= ST_DRAIN;
        ST_DRAIN: if (!own_cyc) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    grant_o = '0;
    if (state != ST_IDLE) grant_o[owner] = 1'b1;
  end

  assign wbs_adr_o = m_adr[owner];
  assign wbs_dat_o = m_dat[owner];
  assign wbs_sel_o = m_sel[owner];
  assign wbs_we_o  = wbm_we_i[owner];
  assign wbs_cti_o = m_cti[owner];
  assign wbs_bte_o = m_bte[owner];
  assign wbs_cyc_o = in_own & own_cyc;
  assign wbs_stb_o = in_own & wbm_stb_i[owner];

  assign wbm_dat_o = {num_masters{wbs_dat_i}};
  assign wbm_ack_o = (in_own && wbs_ack_i) ? grant_o : '0;
  assign wbm_rty_o = (in_own && wbs_rty_i) ? grant_o : '0;
  assign wbm_err_o = ((in_own && wbs_err_i) || state == ST_ABORT) ? grant_o : '0;
  assign timeout_o = (state == ST_ABORT);

endmodule
